// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file and its busy scoreboard.
package regfile_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 16;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on allocate, cleared on write-with-release, with optional
// same-cycle release forwarding onto the read-side busy outputs.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] rd,
  input  logic [NWR-1:0]    rel,
  input  logic              alloc,
  input  logic [AW-1:0]     alloc_rd,
  input  logic [NRD*AW-1:0] rs,
  output logic [NRD-1:0]    rs_busy
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] clr;
  logic [NREGS-1:0] set;
  logic [NREGS-1:0] busy_nxt;
  logic [AW-1:0]    ra;

  // Set is applied after clear so a newer producer keeps the register busy.
  always_comb begin
    clr = '0;
    set = '0;
    for (int w = 0; w < NWR; w++) begin
      if (we[w] && rel[w] && rd[w*AW +: AW] != '0)
        clr[rd[w*AW +: AW]] = 1'b1;
    end
    if (alloc && alloc_rd != '0)
      set[alloc_rd] = 1'b1;
    busy_nxt = (busy & ~clr) | set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  always_comb begin
    rs_busy = '0;
    ra      = '0;
    for (int r = 0; r < NRD; r++) begin
      ra         = rs[r*AW +: AW];
      rs_busy[r] = busy[ra];
      if (BYPASS != 0 && clr[ra])
        rs_busy[r] = 1'b0;
      if (ra == '0)
        rs_busy[r] = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file (r0 hardwired zero) with write-to-read bypass
// and an integrated RAW busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   rd,
  input  logic [NWR*XLEN-1:0] rd_data,
  input  logic [NWR-1:0]      rel,
  input  logic [NRD*AW-1:0]   rs,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                alloc,
  input  logic [AW-1:0]       alloc_rd
);

  logic [XLEN-1:0] mem [NREGS];
  logic [AW-1:0]   ra;
  logic [XLEN-1:0] rv;

  // Later ports are assigned last, so the highest-index writer wins on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        mem[i] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (we[w] && rd[w*AW +: AW] != '0)
          mem[rd[w*AW +: AW]] <= rd_data[w*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rs_data = '0;
    ra      = '0;
    rv      = '0;
    for (int r = 0; r < NRD; r++) begin
      ra = rs[r*AW +: AW];
      rv = mem[ra];
      if (BYPASS != 0) begin
        for (int w = 0; w < NWR; w++) begin
          if (we[w] && rd[w*AW +: AW] == ra)
            rv = rd_data[w*XLEN +: XLEN];
        end
      end
      if (ra == '0)
        rv = '0;
      rs_data[r*XLEN +: XLEN] = rv;
    end
  end

  rf_scoreboard #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .NWR    (NWR),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .rd       (rd),
    .rel      (rel),
    .alloc    (alloc),
    .alloc_rd (alloc_rd),
    .rs       (rs),
    .rs_busy  (rs_busy)
  );

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with an integrated per-register busy scoreboard and optional write-to-read bypass. It is the next-generation register file for the core. It adds configurable width, depth, read- and write-port counts, and asynchronous reset. It also tracks which architectural registers have an in-flight producer, so issue logic can stall on RAW hazards without a separate structure. It sits between decode/issue (read and allocate) and writeback (write and release).

## Interface
- `XLEN`, default 32: data width in bits.
- `NREGS`, default 16: number of architectural registers, power of two, ≥2; `AW = $clog2(NREGS)`.
- `NRD`, default 2: number of read ports, ≥1.
- `NWR`, default 1: number of write ports, 1..4.
- `BYPASS`, default 1: 1 = same-cycle write-to-read forwarding; 0 = reads see only stored state.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `we` input NWR: per-port write enable.
- `rd` input NWR×AW: per-port write address.
- `rd_data` input NWR×XLEN: per-port write data.
- `rel` input NWR: per-port scoreboard release; clears busy of `rd[w]` when `we[w]` is also high.
- `rs` input NRD×AW: read addresses.
- `rs_data` output NRD×XLEN: read data, combinational.
- `rs_busy` output NRD: busy bit of `rs[r]`, combinational.
- `alloc` input 1: mark `alloc_rd` busy (destination issued).
- `alloc_rd` input AW: register to allocate.

## Operation
- Register 0 is hardwired zero.
  - Writes to it are discarded.
  - `rs_data` is 0 and `rs_busy` is 0 for `rs == 0`, regardless of bypass.
  - Allocating register 0 is a no-op.
- Reset (`rst_n` low, asynchronous): all registers clear to 0 and all busy bits clear to 0 immediately. They stay cleared while reset is held. Outputs then reflect the cleared state.
- Write: on each rising edge, every port with `we[w]` and `rd[w] != 0` stores `rd_data[w]`.
  - If several ports target the same register in one cycle, the highest-index port wins.
- Release: `we[w] & rel[w] & rd[w] != 0` clears `busy[rd[w]]`.
  - `rel` without `we` is ignored.
- Allocate: `alloc & alloc_rd != 0` sets `busy[alloc_rd]`.
  - If allocate and release hit the same register in the same cycle, set wins, because a newer producer exists.
- Read, `BYPASS=1`:
  - If any port has `we[w]` with `rd[w] == rs[r] != 0`, `rs_data[r]` is `rd_data` of the highest-index such port. Otherwise it is the stored value.
  - `rs_busy[r]` is the stored busy bit, cleared if a same-cycle release targets `rs[r]`.
  - A same-cycle `alloc` does not affect `rs_busy`.
- Read, `BYPASS=0`: `rs_data` and `rs_busy` reflect stored state only.
- Every read port is independent. Multiple ports may read the same address.

## Timing
- Read-path latency is 0 cycles (combinational from `rs`).
- A write in cycle N is visible on reads in cycle N with `BYPASS=1`, and in cycle N+1 with `BYPASS=0`.
- An allocate in cycle N makes `rs_busy` read 1 from cycle N+1.
- A release in cycle N makes `rs_busy` read 0 in cycle N with `BYPASS=1`, and in N+1 with `BYPASS=0`.
- Reset asserted mid-operation discards any writes, allocates and releases pending in that cycle. There is no partial update.
- There is no handshake or back-pressure. Callers guarantee addresses are valid when enables are high.

## Structure
- Shared package `regfile_pkg`:
  - defaults for `XLEN` and `NREGS`;
  - `reg_addr_t` (AW-bit logic);
  - `xlen_t`.
- One sub-module: `rf_scoreboard`. It holds the NREGS busy bits, alloc/release priority and the release-bypass for `rs_busy`.
- The data array and forwarding muxes stay in `regfile_mp`. The array has no reset-free optimisation, because the whole array is asynchronously reset.

## Test plan
- Reset, then read: pulse `rst_n` low mid-run after writing 0xDEADBEEF to r5 → r5 reads 0 and `rs_busy` is 0 for every register immediately on reset assertion.
- Register 0 is hardwired: write 0x1234 to r0 with `alloc_rd = 0` → `rs_data = 0` and `rs_busy = 0` on all ports, in the same cycle and afterwards.
- Bypass: with `BYPASS=1`, write 0xA5A5A5A5 to r3 while `rs[0] = 3` → 0xA5A5A5A5 the same cycle. Repeat with `BYPASS=0` → old value this cycle, new value next cycle.
- Write-port priority: with `NWR = 2`, ports 0 and 1 both write r7 (0x11, 0x22) → stored and bypassed value is 0x22.
- Scoreboard: allocate r4 in cycle N → `rs_busy = 1` at N+1. Write r4 with `rel` at N+3 → `rs_busy = 0` at N+3 with `BYPASS=1`, and at N+4 with `BYPASS=0`. Then allocate and release r4 in the same cycle → r4 busy.
- Multi-port read: `NRD = 3` with all ports reading r9 = 0x55 → all three outputs are 0x55.
